// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, window geometry and pixel types
// used by the scan-out block and its palette ROM.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] H_LAST    = H_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_LAST    = V_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Frame-buffer image is 256x240; native mode places it top-left,
  // doubled mode centres a 512x480 copy horizontally.
  localparam logic [9:0] NATIVE_W    = 10'd256;
  localparam logic [9:0] NATIVE_H    = 10'd240;
  localparam logic [9:0] S2X_H_START = 10'd64;
  localparam logic [9:0] S2X_H_END   = S2X_H_START + 10'd512;

  localparam logic [9:0] OOR_ADDR  = 10'h3FF;
  localparam logic [5:0] NES_BLACK = 6'h3F;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/nes_palette_rom.sv
// Fixed 64-entry NES 2C02 palette, 6-bit index to RGB444; purely combinational,
// the caller registers the output.
module nes_palette_rom
  import vga_pkg::*;
(
  input  logic [5:0] idx_i,
  output rgb444_t    rgb_o
);

  logic [11:0] rgb12;

  always_comb begin
    rgb12 = 12'h000;
    case (idx_i)
      6'h00: rgb12 = 12'h777;
      6'h01: rgb12 = 12'h00F;
      6'h02: rgb12 = 12'h00B;
      6'h03: rgb12 = 12'h42B;
      6'h04: rgb12 = 12'h908;
      6'h05: rgb12 = 12'hA02;
      6'h06: rgb12 = 12'hA10;
      6'h07: rgb12 = 12'h810;
      6'h08: rgb12 = 12'h530;
      6'h09: rgb12 = 12'h070;
      6'h0A: rgb12 = 12'h060;
      6'h0B: rgb12 = 12'h050;
      6'h0C: rgb12 = 12'h045;
      6'h0D: rgb12 = 12'h000;
      6'h0E: rgb12 = 12'h000;
      6'h0F: rgb12 = 12'h000;
      6'h10: rgb12 = 12'hBBB;
      6'h11: rgb12 = 12'h07F;
      6'h12: rgb12 = 12'h05F;
      6'h13: rgb12 = 12'h64F;
      6'h14: rgb12 = 12'hD0C;
      6'h15: rgb12 = 12'hE05;
      6'h16: rgb12 = 12'hF30;
      6'h17: rgb12 = 12'hE51;
      6'h18: rgb12 = 12'hA70;
      6'h19: rgb12 = 12'h0B0;
      6'h1A: rgb12 = 12'h0A0;
      6'h1B: rgb12 = 12'h0A4;
      6'h1C: rgb12 = 12'h088;
      6'h1D: rgb12 = 12'h000;
      6'h1E: rgb12 = 12'h000;
      6'h1F: rgb12 = 12'h000;
      6'h20: rgb12 = 12'hFFF;
      6'h21: rgb12 = 12'h3BF;
      6'h22: rgb12 = 12'h68F;
      6'h23: rgb12 = 12'h97F;
      6'h24: rgb12 = 12'hF7F;
      6'h25: rgb12 = 12'hF59;
      6'h26: rgb12 = 12'hF75;
      6'h27: rgb12 = 12'hFA4;
      6'h28: rgb12 = 12'hFB0;
      6'h29: rgb12 = 12'hBF1;
      6'h2A: rgb12 = 12'h5D5;
      6'h2B: rgb12 = 12'h5F9;
      6'h2C: rgb12 = 12'h0ED;
      6'h2D: rgb12 = 12'h777;
      6'h2E: rgb12 = 12'h000;
      6'h2F: rgb12 = 12'h000;
      6'h30: rgb12 = 12'hFFF;
      6'h31: rgb12 = 12'hAEF;
      6'h32: rgb12 = 12'hBBF;
      6'h33: rgb12 = 12'hDBF;
      6'h34: rgb12 = 12'hFBF;
      6'h35: rgb12 = 12'hFAC;
      6'h36: rgb12 = 12'hFDB;
      6'h37: rgb12 = 12'hFEA;
      6'h38: rgb12 = 12'hFD7;
      6'h39: rgb12 = 12'hDF7;
      6'h3A: rgb12 = 12'hBFB;
      6'h3B: rgb12 = 12'hBFD;
      6'h3C: rgb12 = 12'h0FF;
      6'h3D: rgb12 = 12'hFDF;
      6'h3E: rgb12 = 12'h000;
      6'h3F: rgb12 = 12'h000;
      default: rgb12 = 12'h000;
    endcase
  end

  assign rgb_o = rgb12;

endmodule

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out: frame-buffer read addressing, NES palette lookup and
// sync generation. Define VGA_SCALE2X_EN for the centred 2x-scaled image.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV = 2,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vga_data,
  output logic [9:0] vga_row,
  output logic [9:0] vga_col,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank,
  output logic       frame_start
);

  localparam int unsigned    PW         = $clog2(PIX_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PIX_DIV - 1);
  // Data is captured one tick after the address moves, so memory must settle within a pixel.
  localparam bit unused_lat_ok = (PIX_DIV >= 2) && (MEM_LAT < PIX_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic          ptick;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;

  logic [9:0]    row_q, row_d;
  logic [9:0]    col_q, col_d;
  logic          in_win;

  logic          hs_raw, vs_raw, blank_raw;
  logic          hs_s1_q, vs_s1_q, blank_s1_q;
  logic          hs_s2_q, vs_s2_q, blank_s2_q;

  logic [5:0]    pal_idx_q;
  rgb444_t       pal_rgb;
  rgb444_t       rgb_q;
  logic          hs_q, vs_q, blank_q, fs_q;

  logic [1:0]    unused_data_hi;
  assign unused_data_hi = vga_data[7:6];

  assign ptick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = ptick ? '0 : presc_q + 1'b1;
    h_d     = h_q;
    v_d     = v_q;
    if (ptick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    row_d  = OOR_ADDR;
    col_d  = OOR_ADDR;
`ifdef VGA_SCALE2X_EN
    in_win = (h_q >= S2X_H_START) && (h_q < S2X_H_END) && (v_q < V_VISIBLE);
    if (in_win) begin
      col_d = (h_q - S2X_H_START) >> 1;
      row_d = v_q >> 1;
    end
`else
    in_win = (h_q < NATIVE_W) && (v_q < NATIVE_H);
    if (in_win) begin
      col_d = h_q;
      row_d = v_q;
    end
`endif
  end

  always_comb begin
    hs_raw    = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    vs_raw    = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    blank_raw = !((h_q < H_VISIBLE) && (v_q < V_VISIBLE));
  end

  nes_palette_rom u_palette (
    .idx_i (pal_idx_q),
    .rgb_o (pal_rgb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      h_q        <= '0;
      v_q        <= '0;
      row_q      <= OOR_ADDR;
      col_q      <= OOR_ADDR;
      hs_s1_q    <= 1'b1;
      vs_s1_q    <= 1'b1;
      blank_s1_q <= 1'b1;
      hs_s2_q    <= 1'b1;
      vs_s2_q    <= 1'b1;
      blank_s2_q <= 1'b1;
      pal_idx_q  <= NES_BLACK;
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_q    <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      presc_q <= presc_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fs_q    <= ptick && (h_q == '0) && (v_q == '0);
      if (ptick) begin
        // S0: address and raw timing flags from the current position
        row_q      <= row_d;
        col_q      <= col_d;
        hs_s1_q    <= hs_raw;
        vs_s1_q    <= vs_raw;
        blank_s1_q <= blank_raw;
        // S1: frame-buffer data for the address issued last tick
        pal_idx_q  <= vga_data[5:0];
        hs_s2_q    <= hs_s1_q;
        vs_s2_q    <= vs_s1_q;
        blank_s2_q <= blank_s1_q;
        // S2: colour and syncs leave together
        rgb_q      <= blank_s2_q ? '0 : pal_rgb;
        hs_q       <= hs_s2_q;
        vs_q       <= vs_s2_q;
        blank_q    <= blank_s2_q;
      end
    end
  end

  assign vga_row     = row_q;
  assign vga_col     = col_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank   = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: reset values, window addressing, palette
// path, sync/blank placement, frame period and mid-frame reset.
module tb_vga_scanout;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vga_data;
  logic [9:0] vga_row, vga_col;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank, frame_start;

  int total = 0;
  int bad = 0;
  int ticks_done = 0;
  int fs_extra = 0;
  int fs_ticks[$];

  logic       use_const = 1'b0;
  logic [7:0] const_data = 8'h00;
  logic [7:0] mem_q = 8'h3F;

  vga_scanout #(.PIX_DIV(2), .MEM_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_data    (vga_data),
    .vga_row     (vga_row),
    .vga_col     (vga_col),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank   (vga_blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Frame buffer with one clk of read latency; out-of-range reads give 3F.
  always @(posedge clk) begin
    if (use_const) mem_q <= const_data;
    else if (vga_row == 10'h3FF || vga_col == 10'h3FF) mem_q <= 8'h3F;
    else mem_q <= {2'b00, vga_col[5:0]};
  end
  assign vga_data = mem_q;

  function automatic int pos(input int h, input int v);
    return v * 800 + h;
  endfunction

  // After k ticks the address reflects position k-1 and RGB/syncs position k-3.
  task automatic adv(input int target);
    while (ticks_done < target) begin
      @(posedge clk); #1;
      if (frame_start !== 1'b0) fs_extra++;
      @(posedge clk); #1;
      ticks_done++;
      if (frame_start === 1'b1) fs_ticks.push_back(ticks_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({vga_row, vga_col} !== {10'h3FF, 10'h3FF}) begin
      bad++; $display("FAIL reset_addr: got %h/%h want 3ff/3ff", vga_row, vga_col);
    end
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      bad++; $display("FAIL reset_rgb: got %h want 000", {vga_r, vga_g, vga_b});
    end
    total++;
    if ({vga_hs, vga_vs, vga_blank, frame_start} !== 4'b1110) begin
      bad++; $display("FAIL reset_ctl: got hs/vs/blank/fs=%b want 1110", {vga_hs, vga_vs, vga_blank, frame_start});
    end
    @(negedge clk);
    rst = 1'b0;
    ticks_done = 0;
    @(posedge clk); #1;
    total++;
    if (frame_start !== 1'b0) begin
      bad++; $display("FAIL first_edge_no_tick: got fs=%b want 0", frame_start);
    end
    @(posedge clk); #1;
    ticks_done = 1;
    if (frame_start === 1'b1) fs_ticks.push_back(ticks_done);
    total++;
    if (frame_start !== 1'b1) begin
      bad++; $display("FAIL first_tick_fs: got %b want 1", frame_start);
    end
`ifdef VGA_SCALE2X_EN
    total++;
    if ({vga_row, vga_col} !== {10'h3FF, 10'h3FF}) begin
      bad++; $display("FAIL first_tick_addr: got %h/%h want 3ff/3ff", vga_row, vga_col);
    end
`else
    total++;
    if ({vga_row, vga_col} !== {10'd0, 10'd0}) begin
      bad++; $display("FAIL first_tick_addr: got %h/%h want 000/000", vga_row, vga_col);
    end
`endif
    total++;
    if (vga_blank !== 1'b1) begin
      bad++; $display("FAIL first_tick_blank: got %b want 1", vga_blank);
    end
  endtask

`ifdef VGA_SCALE2X_EN
  task automatic test_scale_on;
    int hs_list[9] = '{63, 64, 65, 575, 576, 64, 65, 70, 64};
    int vs_list[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 2};
    logic [19:0] want[9] = '{ {10'h3FF, 10'h3FF}, {10'd0, 10'd0}, {10'd0, 10'd0},
                              {10'd0, 10'd255}, {10'h3FF, 10'h3FF}, {10'd0, 10'd0},
                              {10'd0, 10'd0}, {10'd0, 10'd3}, {10'd1, 10'd0} };
    for (int i = 0; i < 9; i++) begin
      adv(pos(hs_list[i], vs_list[i]) + 1);
      total++;
      if ({vga_row, vga_col} !== want[i]) begin
        bad++; $display("FAIL s2x_addr h=%0d v=%0d: got %h/%h want %h/%h", hs_list[i], vs_list[i],
                        vga_row, vga_col, want[i][19:10], want[i][9:0]);
      end
      if (i == 7) begin
        adv(pos(70, 1) + 3);
        total++;
        if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b0, 12'h42B}) begin
          bad++; $display("FAIL s2x_rgb: got blank=%b rgb=%h want 0/42b", vga_blank, {vga_r, vga_g, vga_b});
        end
      end
    end
  endtask
`else
  task automatic test_scale_off;
    adv(pos(5, 3) + 1);
    total++;
    if ({vga_row, vga_col} !== {10'd3, 10'd5}) begin
      bad++; $display("FAIL addr_5_3: got %h/%h want 003/005", vga_row, vga_col);
    end
    adv(pos(5, 3) + 3);
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b0, 12'hA02}) begin
      bad++; $display("FAIL rgb_5_3: got blank=%b rgb=%h want 0/a02", vga_blank, {vga_r, vga_g, vga_b});
    end
    adv(pos(100, 3) + 1);
    total++;
    if ({vga_row, vga_col} !== {10'd3, 10'd100}) begin
      bad++; $display("FAIL addr_100_3: got %h/%h want 003/064", vga_row, vga_col);
    end
    adv(pos(100, 3) + 3);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'hF7F) begin
      bad++; $display("FAIL rgb_100_3: got %h want f7f", {vga_r, vga_g, vga_b});
    end
    adv(pos(255, 3) + 1);
    total++;
    if ({vga_row, vga_col} !== {10'd3, 10'd255}) begin
      bad++; $display("FAIL addr_255_3: got %h/%h want 003/0ff", vga_row, vga_col);
    end
    adv(pos(256, 3) + 1);
    total++;
    if ({vga_row, vga_col} !== {10'h3FF, 10'h3FF}) begin
      bad++; $display("FAIL addr_256_3: got %h/%h want 3ff/3ff", vga_row, vga_col);
    end
    adv(pos(300, 3) + 1);
    total++;
    if ({vga_row, vga_col} !== {10'h3FF, 10'h3FF}) begin
      bad++; $display("FAIL addr_300_3: got %h/%h want 3ff/3ff", vga_row, vga_col);
    end
    adv(pos(300, 3) + 3);
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b0, 12'h000}) begin
      bad++; $display("FAIL rgb_300_3: got blank=%b rgb=%h want 0/000", vga_blank, {vga_r, vga_g, vga_b});
    end
  endtask
`endif

  task automatic test_hsync;
    int lo = 0;
    int first = -1;
    int vlo = 0;
    for (int x = 0; x < 800; x++) begin
      adv(pos(x, 5) + 3);
      if (vga_hs === 1'b0) begin
        lo++;
        if (first < 0) first = x;
      end
      if (vga_vs === 1'b0) vlo++;
    end
    total++;
    if (lo !== 96) begin
      bad++; $display("FAIL hs_low_ticks: got %0d want 96", lo);
    end
    total++;
    if (first !== 656) begin
      bad++; $display("FAIL hs_first_low: got h=%0d want 656", first);
    end
    total++;
    if (vlo !== 0) begin
      bad++; $display("FAIL vs_on_line5: got %0d low ticks want 0", vlo);
    end
  endtask

  task automatic test_upper_bits;
    use_const = 1'b1;
    const_data = 8'hFF;
    adv(pos(10, 20) + 3);
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b0, 12'h000}) begin
      bad++; $display("FAIL data_ff: got blank=%b rgb=%h want 0/000", vga_blank, {vga_r, vga_g, vga_b});
    end
    const_data = 8'hE1;
    adv(pos(10, 21) + 3);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'h3BF) begin
      bad++; $display("FAIL data_e1: got %h want 3bf", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_blank;
    int vlo = 0;
    int vfirst = -1;
    int blank_bad = 0;
    const_data = 8'h21;
    adv(pos(639, 30) + 3);
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b0, 12'h3BF}) begin
      bad++; $display("FAIL blank_h639: got blank=%b rgb=%h want 0/3bf", vga_blank, {vga_r, vga_g, vga_b});
    end
    adv(pos(640, 30) + 3);
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b1, 12'h000}) begin
      bad++; $display("FAIL blank_h640: got blank=%b rgb=%h want 1/000", vga_blank, {vga_r, vga_g, vga_b});
    end
    adv(pos(799, 30) + 3);
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b1, 12'h000}) begin
      bad++; $display("FAIL blank_h799: got blank=%b rgb=%h want 1/000", vga_blank, {vga_r, vga_g, vga_b});
    end
    adv(pos(0, 479) + 3);
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b0, 12'h3BF}) begin
      bad++; $display("FAIL blank_v479: got blank=%b rgb=%h want 0/3bf", vga_blank, {vga_r, vga_g, vga_b});
    end
    for (int y = 480; y < 525; y++) begin
      for (int x = 0; x < 800; x++) begin
        adv(pos(x, y) + 3);
        if (vga_vs === 1'b0) begin
          vlo++;
          if (vfirst < 0) vfirst = pos(x, y);
        end
        if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b1, 12'h000}) blank_bad++;
      end
    end
    total++;
    if (blank_bad !== 0) begin
      bad++; $display("FAIL vblank_rgb: got %0d unblanked ticks want 0", blank_bad);
    end
    total++;
    if (vlo !== 1600) begin
      bad++; $display("FAIL vs_low_ticks: got %0d want 1600", vlo);
    end
    total++;
    if (vfirst !== pos(0, 490)) begin
      bad++; $display("FAIL vs_first_low: got pos %0d want %0d", vfirst, pos(0, 490));
    end
  endtask

  task automatic test_frame_period;
    int p0 = (fs_ticks.size() > 0) ? fs_ticks[0] : -1;
    int p1 = (fs_ticks.size() > 1) ? fs_ticks[1] : -1;
    total++;
    if (fs_ticks.size() !== 2) begin
      bad++; $display("FAIL fs_count: got %0d pulses want 2", fs_ticks.size());
    end
    total++;
    if (p1 - p0 !== 420000) begin
      bad++; $display("FAIL frame_period: got %0d ticks want 420000", p1 - p0);
    end
    total++;
    if (fs_extra !== 0) begin
      bad++; $display("FAIL fs_width: got %0d off-tick highs want 0", fs_extra);
    end
  endtask

  task automatic test_reset_mid;
    adv(420000 + pos(400, 200));
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b0, 12'h3BF}) begin
      bad++; $display("FAIL pre_reset_rgb: got blank=%b rgb=%h want 0/3bf", vga_blank, {vga_r, vga_g, vga_b});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({vga_row, vga_col} !== {10'h3FF, 10'h3FF}) begin
      bad++; $display("FAIL mid_reset_addr: got %h/%h want 3ff/3ff", vga_row, vga_col);
    end
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b1, 12'h000}) begin
      bad++; $display("FAIL mid_reset_rgb: got blank=%b rgb=%h want 1/000", vga_blank, {vga_r, vga_g, vga_b});
    end
    total++;
    if ({vga_hs, vga_vs, frame_start} !== 3'b110) begin
      bad++; $display("FAIL mid_reset_ctl: got hs/vs/fs=%b want 110", {vga_hs, vga_vs, frame_start});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ticks_done = 0;
    fs_ticks.delete();
    adv(1);
    total++;
    if (fs_ticks.size() !== 1) begin
      bad++; $display("FAIL post_reset_fs: got %0d pulses want 1", fs_ticks.size());
    end
    adv(2);
    total++;
    if ({vga_blank, vga_r, vga_g, vga_b} !== {1'b1, 12'h000}) begin
      bad++; $display("FAIL post_reset_t2: got blank=%b rgb=%h want 1/000", vga_blank, {vga_r, vga_g, vga_b});
    end
    adv(3);
    total++;
    if ({vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b} !== {3'b110, 12'h3BF}) begin
      bad++; $display("FAIL post_reset_t3: got hs/vs/blank=%b rgb=%h want 110/3bf",
                      {vga_hs, vga_vs, vga_blank}, {vga_r, vga_g, vga_b});
    end
    adv(pos(655, 0) + 3);
    total++;
    if (vga_hs !== 1'b1) begin
      bad++; $display("FAIL post_reset_hs655: got %b want 1", vga_hs);
    end
    adv(pos(656, 0) + 3);
    total++;
    if (vga_hs !== 1'b0) begin
      bad++; $display("FAIL post_reset_hs656: got %b want 0", vga_hs);
    end
    adv(420001);
    total++;
    if (fs_ticks.size() !== 2 || fs_ticks[fs_ticks.size() - 1] !== 420001) begin
      bad++; $display("FAIL post_reset_period: got %0d pulses, last at tick %0d want 2 and 420001",
                      fs_ticks.size(), (fs_ticks.size() > 0) ? fs_ticks[fs_ticks.size() - 1] : -1);
    end
  endtask

  initial begin
    #40_000_000;
    $display("FAIL watchdog: got time limit want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
`ifdef VGA_SCALE2X_EN
    test_scale_on();
`else
    test_scale_off();
`endif
    test_hsync();
    test_upper_bits();
    test_blank();
    test_frame_period();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Pixel-stream generator on the read side of the frame buffer. Runs 640x480@60 Hz VGA timing, drives the frame buffer's `vga_row`/`vga_col` read address, and captures the returned 8-bit NES palette index. Maps each index through a 64-entry NES palette to 12-bit RGB, and emits RGB plus hsync/vsync aligned to the monitor.

## Interface
- `PIX_DIV`, default 2: `clk` cycles per pixel; minimum 2.
- `MEM_LAT`, default 1: `clk` cycles from an address change to valid `vga_data`; must be < `PIX_DIV`.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `vga_data` in 8: palette index returned by the frame buffer; only bits [5:0] are used.
- `vga_row` out 10: frame-buffer read row.
- `vga_col` out 10: frame-buffer read column.
- `vga_r`, `vga_g`, `vga_b` out 4 each: pixel colour.
- `vga_hs`, `vga_vs` out 1 each: sync, active low.
- `vga_blank` out 1: high outside the 640x480 visible area.
- `frame_start` out 1: one-`clk` pulse on the pixel tick where h=0, v=0.

## Operation
- Prescaler counts 0..`PIX_DIV`-1. A pixel tick (`ptick`) fires when it wraps; all pixel state advances only on `ptick`.
- `h` counts 0..799 and wraps to 0. `v` increments when `h` wraps and counts 0..524, wrapping to 0.
- Horizontal timing: visible h<640; hsync low for 656<=h<752.
- Vertical timing: visible v<480; vsync low for 490<=v<492.
- Window mapping, registered on `ptick` from current h/v:
  - Inside the window: `vga_row`/`vga_col` = frame-buffer coordinates.
  - Outside the window: both = 10'h3FF. The frame buffer treats this as out of range and returns 8'h3F, which maps to black.
- 3-stage pixel pipeline, one stage per `ptick`:
  - S0: counters; address registered.
  - S1: `vga_data[5:0]` captured into `pal_idx`.
  - S2: RGB registered from the palette ROM; hs/vs/blank are delayed two ticks so they stay aligned with RGB.
- RGB is forced to 0 whenever the delayed blank is 1, independent of `pal_idx`.
- Palette: fixed 64x12 ROM of NES 2C02 colours. Index 0x3F = 12'h000.

## Timing
- Reset values:
  - Prescaler, h, v = 0.
  - `vga_row`/`vga_col` = 10'h3FF.
  - `pal_idx` = 6'h3F.
  - RGB = 0.
  - `vga_hs` = `vga_vs` = 1.
  - `vga_blank` = 1.
  - `frame_start` = 0.
- First `ptick` occurs `PIX_DIV` cycles after reset deasserts.
- Latency is 2 `ptick`s from address out to RGB out, and equally from counter position to sync out.
- `vga_data` is sampled on the `ptick` following the address change. This is legal because `MEM_LAT` < `PIX_DIV`.
- End of line and end of frame fall on the same tick (h=799, v=524). Both counters wrap together, and `frame_start` pulses on the next tick.
- Reset mid-frame: all state returns immediately to reset values and timing restarts at h=0, v=0. Syncs stay inactive until their normal positions are reached.
- Frame period = 800*525*`PIX_DIV` `clk` cycles exactly.

## Configuration
- `VGA_SCALE2X_EN` defined:
  - Window is 64<=h<576, v<480.
  - `vga_col` = (h-64)>>1, `vga_row` = v>>1.
  - The 256x240 image is doubled and centred.
- `VGA_SCALE2X_EN` not defined:
  - Window is h<256, v<240.
  - `vga_col` = h, `vga_row` = v.
  - Native size, top-left; the rest of the screen is black.

## Structure
- Shared package `vga_pkg` holds:
  - The H/V timing constants (visible, front porch, sync, back porch, total).
  - `OOR_ADDR` = 10'h3FF.
  - `NES_BLACK` = 6'h3F.
  - The RGB444 typedef.
- One sub-module, `nes_palette_rom`: combinational 6-bit in, 12-bit out. `vga_scanout` registers its output.

## Test plan
- Reset release, run one full frame: exactly 420000 `ptick`s (840000 `clk` at `PIX_DIV`=2) between `frame_start` pulses. Per line, `vga_hs` is low for 96 ticks; per frame, `vga_vs` is low for 2 lines.
- Scale off, `vga_data` model returns `col[5:0]`: at h=5, v=3, address = (3,5), and RGB equals palette[5] two ticks later. At h=300, address = 3FF/3FF and RGB = 0.
- Scale on: h=64..65 and v=0..1 all address (0,0). h=575 gives col 255; h=576 gives 3FF.
- Blanking: `vga_data` = 8'h21 held constant; RGB = 0 for h>=640 (delayed by 2) and during v>=480. `vga_blank` = 1 on those ticks.
- Assert `rst` at h=400, v=200 for 3 cycles: outputs go to reset values immediately; the first `frame_start` comes 420000 ticks after the first post-reset tick.
- `vga_data` = 8'hFF: upper bits ignored, RGB = palette[0x3F] = 12'h000.
